// File: rtl/trng_pkg.sv
// trng_pkg: shared widths and defaults for the TRNG collector slice.
// Word/byte widths, default parameters, fifo_level width helper.
package trng_pkg;

   localparam int WORD_W         = 32;
   localparam int BYTE_W         = 8;
   localparam int DEF_FIFO_DEPTH = 8;
   localparam int DEF_REP_LIMIT  = 16;
   localparam int DEF_WARMUP     = 8;

   // Level counter must hold 0..DEPTH inclusive.
   function automatic int lvl_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/trng_fifo.sv
// trng_fifo: synchronous first-word-fall-through word FIFO.
// Ports: clk, rst (async high), i_push/i_data, i_pop, i_flush,
//        o_data (head, 0 when empty), o_valid, o_full, o_level.
module trng_fifo
   import trng_pkg::*;
#(
   parameter int DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic [WORD_W-1:0]        i_data,
   input  logic                     i_pop,
   input  logic                     i_flush,
   output logic [WORD_W-1:0]        o_data,
   output logic                     o_valid,
   output logic                     o_full,
   output logic [lvl_w(DEPTH)-1:0]  o_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = lvl_w(DEPTH);

   logic [WORD_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr;
   logic [AW-1:0]     r_rd;
   logic [LW-1:0]     r_level;
   logic              w_push;
   logic              w_pop;

   assign o_full  = (r_level == LW'(DEPTH));
   assign o_valid = (r_level != '0);
   assign o_level = r_level;
   assign o_data  = o_valid ? r_mem[r_rd] : '0;

   assign w_push = i_push & ~o_full;
   assign w_pop  = i_pop & o_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_level <= '0;
      end else if (i_flush) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_level <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + 1'b1;
         if (w_pop)  r_rd <= r_rd + 1'b1;
         unique case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push && !i_flush) r_mem[r_wr] <= i_data;
   end

endmodule

// File: rtl/trng_collector.sv
// trng_collector: gates the TRNG core, drops warm-up bytes, runs a
// repetition-count health test and packs bytes into FIFO'd words.
// Ports: clk, rst (async high), enable, trng_en, raw[7:0],
//        out_valid/out_ready/out_data[31:0], health_fail, clr_fail,
//        fifo_level. Macro TRNG_VN_DEBIAS_EN selects von Neumann
//        debiasing in place of plain 4-byte packing.
module trng_collector
   import trng_pkg::*;
#(
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int REP_LIMIT  = DEF_REP_LIMIT,
   parameter int WARMUP     = DEF_WARMUP
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          enable,
   output logic                          trng_en,
   input  logic [BYTE_W-1:0]             raw,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [WORD_W-1:0]             out_data,
   output logic                          health_fail,
   input  logic                          clr_fail,
   output logic [lvl_w(FIFO_DEPTH)-1:0]  fifo_level
);

   logic              r_en;
   logic              r_fail;
   logic [7:0]        r_warm;
   logic [7:0]        r_rep;
   logic [7:0]        r_last;

   logic              w_full;
   logic              w_restart;
   logic              w_live;
   logic [7:0]        w_rep_nxt;
   logic              w_trip;
   logic              w_pack;
   logic              w_push;
   logic [WORD_W-1:0] w_word;

   // enable is registered so trng_en depends only on flops.
   assign trng_en     = r_en & ~r_fail & ~w_full;
   assign health_fail = r_fail;

   assign w_restart = clr_fail | (r_en & ~enable);
   // A restart swallows any byte accepted on the same edge.
   assign w_live    = trng_en & ~w_restart & (r_warm == 8'd0);
   assign w_rep_nxt = (raw == r_last) ? r_rep + 8'd1 : 8'd1;
   assign w_trip    = w_live & (w_rep_nxt == 8'(REP_LIMIT));
   assign w_pack    = w_live & ~w_trip;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_en   <= 1'b0;
         r_fail <= 1'b0;
         r_warm <= 8'(WARMUP);
         r_rep  <= 8'd0;
         r_last <= 8'd0;
      end else begin
         r_en <= enable;
         if (w_restart) begin
            r_warm <= 8'(WARMUP);
            r_rep  <= 8'd0;
            r_last <= 8'd0;
            if (clr_fail) r_fail <= 1'b0;
         end else if (trng_en) begin
            if (r_warm != 8'd0) begin
               r_warm <= r_warm - 8'd1;
            end else begin
               r_rep  <= w_rep_nxt;
               r_last <= raw;
               if (w_trip) r_fail <= 1'b1;
            end
         end
      end
   end

`ifdef TRNG_VN_DEBIAS_EN
   logic [WORD_W-1:0] r_vword;
   logic [4:0]        r_vcnt;
   logic [WORD_W-1:0] w_vword_nxt;
   logic [5:0]        w_vcnt_nxt;
   logic              w_vpush;
   logic [WORD_W-1:0] w_vout;

   // Walk the four pairs LSB first; at most one word can fill per byte.
   always_comb begin
      w_vword_nxt = r_vword;
      w_vcnt_nxt  = {1'b0, r_vcnt};
      w_vpush     = 1'b0;
      w_vout      = '0;
      for (int i = 0; i < 4; i++) begin
         if (raw[2*i] ^ raw[2*i+1]) begin
            w_vword_nxt[w_vcnt_nxt[4:0]] = raw[2*i+1];
            w_vcnt_nxt = w_vcnt_nxt + 6'd1;
            if (w_vcnt_nxt == 6'd32) begin
               w_vpush     = 1'b1;
               w_vout      = w_vword_nxt;
               w_vword_nxt = '0;
               w_vcnt_nxt  = '0;
            end
         end
      end
   end

   assign w_push = w_pack & w_vpush;
   assign w_word = w_vout;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vword <= '0;
         r_vcnt  <= '0;
      end else if (w_restart || w_trip) begin
         r_vword <= '0;
         r_vcnt  <= '0;
      end else if (w_pack) begin
         r_vword <= w_vword_nxt;
         r_vcnt  <= w_vcnt_nxt[4:0];
      end
   end
`else
   logic [23:0] r_word;
   logic [1:0]  r_bcnt;

   // The 4th byte goes straight into the pushed word, never stored.
   assign w_push = w_pack & (r_bcnt == 2'd3);
   assign w_word = {raw, r_word};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_word <= '0;
         r_bcnt <= '0;
      end else if (w_restart || w_trip) begin
         r_word <= '0;
         r_bcnt <= '0;
      end else if (w_pack) begin
         unique case (r_bcnt)
            2'd0:    r_word[7:0]   <= raw;
            2'd1:    r_word[15:8]  <= raw;
            2'd2:    r_word[23:16] <= raw;
            default: ;
         endcase
         r_bcnt <= r_bcnt + 2'd1;
      end
   end
`endif

   trng_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (w_word),
      .i_pop   (out_valid & out_ready),
      .i_flush (w_trip),
      .o_data  (out_data),
      .o_valid (out_valid),
      .o_full  (w_full),
      .o_level (fifo_level)
   );

endmodule

// File: tb/tb_trng_collector.sv
// tb_trng_collector: directed-vector bench for trng_collector.
// Default parameters; TRNG_VN_DEBIAS_EN selects the debias vectors.
module tb_trng_collector;
   import trng_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic        out_ready = 1'b0;
   logic        clr_fail = 1'b0;
   logic [7:0]  raw = 8'h00;
   logic        trng_en;
   logic        out_valid;
   logic        health_fail;
   logic [31:0] out_data;
   logic [3:0]  fifo_level;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   trng_collector dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .trng_en     (trng_en),
      .raw         (raw),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .health_fail (health_fail),
      .clr_fail    (clr_fail),
      .fifo_level  (fifo_level)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic feed(input logic [7:0] b);
      int n = 0;
      while (!trng_en && n < 50) begin
         tick();
         n++;
      end
      if (!trng_en) chk("feed_timeout", {31'd0, trng_en}, 32'd1);
      raw = b;
      tick();
   endtask

   task automatic warm(input logic [7:0] base);
      for (int i = 0; i < 8; i++) feed(base + 8'(i));
   endtask

   task automatic feed_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) feed(w[8*i +: 8]);
   endtask

   task automatic pop_chk(input string tag, input logic [31:0] exp);
      chk(tag, out_data, exp);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   function automatic logic [31:0] mkw(input logic [7:0] b);
      return {b + 8'd3, b + 8'd2, b + 8'd1, b};
   endfunction

   initial begin
      tick();
      tick();
      chk("rst_en",    {31'd0, trng_en},     32'd0);
      chk("rst_valid", {31'd0, out_valid},   32'd0);
      chk("rst_fail",  {31'd0, health_fail}, 32'd0);
      chk("rst_data",  out_data,             32'd0);
      chk("rst_level", {28'd0, fifo_level},  32'd0);
      rst = 1'b0;
      tick();

      enable = 1'b1;
      chk("en_pre", {31'd0, trng_en}, 32'd0);
      tick();
      chk("en_rise", {31'd0, trng_en}, 32'd1);

`ifdef TRNG_VN_DEBIAS_EN
      warm(8'h10);
      for (int i = 0; i < 7; i++) feed(8'h66);
      chk("vn_lvl7", {28'd0, fifo_level}, 32'd0);
      feed(8'h66);
      chk("vn_lvl", {28'd0, fifo_level}, 32'd1);
      chk("vn_data", out_data, 32'h5555_5555);
      chk("vn_fail", {31'd0, health_fail}, 32'd0);
`else
      // warm-up drop and byte order
      warm(8'h10);
      feed(8'h01);
      feed(8'h02);
      feed(8'h03);
      chk("pk_partial", {31'd0, out_valid}, 32'd0);
      feed(8'h04);
      chk("pk_data",  out_data,            32'h0403_0201);
      chk("pk_valid", {31'd0, out_valid},  32'd1);
      chk("pk_level", {28'd0, fifo_level}, 32'd1);

      // backpressure
      for (int b = 5; b <= 'h1d; b += 4) feed_word(mkw(8'(b)));
      chk("bp_level", {28'd0, fifo_level}, 32'd8);
      chk("bp_en",    {31'd0, trng_en},    32'd0);
      tick();
      tick();
      chk("bp_hold", {28'd0, fifo_level}, 32'd8);
      chk("bp_head", out_data, 32'h0403_0201);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("bp_en_back", {31'd0, trng_en},    32'd1);
      chk("bp_lvl7",    {28'd0, fifo_level}, 32'd7);
      chk("bp_head2",   out_data,            32'h0807_0605);
      feed_word(mkw(8'h21));
      chk("bp_refill", {28'd0, fifo_level}, 32'd8);
      enable = 1'b0;
      for (int b = 5; b <= 'h21; b += 4) pop_chk("bp_drain", mkw(8'(b)));
      chk("bp_empty_v", {31'd0, out_valid},  32'd0);
      chk("bp_empty_l", {28'd0, fifo_level}, 32'd0);
      chk("bp_empty_d", out_data,            32'd0);

      // enable drop mid-word
      enable = 1'b1;
      tick();
      warm(8'h30);
      feed(8'hAA);
      feed(8'hBB);
      chk("ed_part", {28'd0, fifo_level}, 32'd0);
      enable = 1'b0;
      tick();
      tick();
      chk("ed_off", {31'd0, trng_en}, 32'd0);
      enable = 1'b1;
      tick();
      warm(8'h40);
      feed_word(32'h5352_5150);
      chk("ed_level", {28'd0, fifo_level}, 32'd1);
      enable = 1'b0;
      pop_chk("ed_data", 32'h5352_5150);
      tick();

      // near-miss on repetition count
      enable = 1'b1;
      tick();
      warm(8'h60);
      for (int i = 0; i < 31; i++) feed(i == 15 ? 8'h5B : 8'h5A);
      chk("nm_fail",  {31'd0, health_fail}, 32'd0);
      chk("nm_level", {28'd0, fifo_level},  32'd7);
      enable = 1'b0;
      for (int k = 0; k < 7; k++)
         pop_chk("nm_word", k == 3 ? 32'h5B5A_5A5A : 32'h5A5A_5A5A);
      chk("nm_empty", {28'd0, fifo_level}, 32'd0);
      tick();

      // health failure and clear
      enable = 1'b1;
      tick();
      warm(8'h70);
      feed_word(32'h1413_1211);
      for (int i = 0; i < 15; i++) feed(8'hA5);
      chk("hf_pre",     {31'd0, health_fail}, 32'd0);
      chk("hf_pre_lvl", {28'd0, fifo_level},  32'd4);
      feed(8'hA5);
      chk("hf_fail",  {31'd0, health_fail}, 32'd1);
      chk("hf_valid", {31'd0, out_valid},   32'd0);
      chk("hf_level", {28'd0, fifo_level},  32'd0);
      chk("hf_en",    {31'd0, trng_en},     32'd0);
      chk("hf_data",  out_data,             32'd0);
      tick();
      tick();
      chk("hf_sticky", {31'd0, health_fail}, 32'd1);
      clr_fail = 1'b1;
      tick();
      clr_fail = 1'b0;
      chk("hf_clr",    {31'd0, health_fail}, 32'd0);
      chk("hf_en_clr", {31'd0, trng_en},     32'd1);
      warm(8'h80);
      feed_word(32'hC4C3_C2C1);
      chk("hf_rlvl",  {28'd0, fifo_level}, 32'd1);
      chk("hf_rdata", out_data,            32'hC4C3_C2C1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
